// File: rtl/dbus_ctrl.sv
// dbus_ctrl: load/store access controller between the core's dbusif_* request
// path and a 32-bit word-addressed memory bus.
//
// One request is accepted at a time. Bytes are placed on lanes using byte
// enables. A misaligned half/word access is split into two aligned beats, and
// the read data from both beats is reassembled. A response timeout applies
// while waiting for bus_rvld. Completion, including any error, is reported
// with a single-cycle dbusif_done pulse.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   dbusif_req      one-cycle request pulse; fields sampled in that cycle
//   dbusif_w_rb     1 = store, 0 = load
//   dbusif_size     0 byte, 1 half, 2 word, 3 illegal
//   dbusif_addr     byte address
//   dbusif_wd       right-aligned store data
//   dbusif_done     completion pulse (also on error)
//   dbusif_err      access faulted, valid with done
//   dbusif_rd       right-aligned, zero-extended load data, valid with done
//   busy            request in flight (cycle after req through done cycle)
//   bus_req/we/addr/be/wdata   address phase outputs (all registered)
//   bus_gnt         address phase accepted
//   bus_rvld/rdata/err         response phase inputs
module dbus_ctrl #(
  parameter int ALLOW_MISALIGN = 1,
  parameter int TIMEOUT        = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbusif_req,
  input  logic        dbusif_w_rb,
  input  logic [1:0]  dbusif_size,
  input  logic [31:0] dbusif_addr,
  input  logic [31:0] dbusif_wd,
  output logic        dbusif_done,
  output logic        dbusif_err,
  output logic [31:0] dbusif_rd,
  output logic        busy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvld,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [2:0] {S_IDLE, S_A1, S_R1, S_A2, S_R2, S_FIN} state_t;

  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

  // Lane mask across two words: low nibble is beat 1, high nibble is beat 2.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] ofs);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << ofs;
  endfunction

  // Right-align the two response words and zero-extend to the access size.
  function automatic logic [31:0] extract_rd(input logic [63:0] hilo, input logic [1:0] ofs,
                                             input logic [1:0] size);
    logic [63:0] sh;
    sh = hilo >> {ofs, 3'b000};
    case (size)
      2'd0:    return {24'h0, sh[7:0]};
      2'd1:    return {16'h0, sh[15:0]};
      default: return sh[31:0];
    endcase
  endfunction

  state_t      r_state, w_state_nxt;
  logic        w_fin_err;

  // Request fields latched at acceptance (data only, never reset)
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_we;
  logic [7:0]  r_m;
  logic [63:0] r_wd64;
  logic [31:0] r_lo;

  logic [7:0]  r_cnt;

  logic        r_done, r_err, r_busy, r_bus_req, r_bus_we;
  logic [31:0] r_rd, r_bus_addr, r_bus_wdata;
  logic [3:0]  r_bus_be;

  logic        w_done_nxt, w_err_nxt, w_busy_nxt, w_bus_req_nxt, w_bus_we_nxt;
  logic [31:0] w_rd_nxt, w_bus_addr_nxt, w_bus_wdata_nxt;
  logic [3:0]  w_bus_be_nxt;

  logic [7:0]  w_m_in;
  logic [63:0] w_wd64_in;
  logic        w_bad_in, w_split, w_tmo;
  logic [7:0]  w_src_m;
  logic [63:0] w_src_wd64;
  logic [31:0] w_src_addr;
  logic        w_src_we;
  logic [63:0] w_hilo;

  assign w_m_in    = lane_mask(dbusif_size, dbusif_addr[1:0]);
  assign w_wd64_in = {32'h0, dbusif_wd} << {dbusif_addr[1:0], 3'b000};
  assign w_bad_in  = (dbusif_size == 2'd3) || ((ALLOW_MISALIGN == 0) && (w_m_in[7:4] != 4'h0));
  assign w_split   = (r_m[7:4] != 4'h0);
  assign w_tmo     = (TIMEOUT != 0) && !bus_rvld && (r_cnt == TO_M1);

  // Beat 1 is launched straight from the request inputs on acceptance and
  // from the latched copy while waiting for grant.
  assign w_src_m    = (r_state == S_IDLE) ? w_m_in      : r_m;
  assign w_src_wd64 = (r_state == S_IDLE) ? w_wd64_in   : r_wd64;
  assign w_src_addr = (r_state == S_IDLE) ? dbusif_addr : r_addr;
  assign w_src_we   = (r_state == S_IDLE) ? dbusif_w_rb : r_we;

  // Response data is formatted in the capture cycle, so the live bus word
  // stands in for the register it is being written into.
  assign w_hilo = (r_state == S_R2) ? {bus_rdata, r_lo} : {32'h0, bus_rdata};

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rd        <= 32'h0;
      r_busy      <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_be    <= 4'h0;
      r_bus_wdata <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_rd        <= w_rd_nxt;
      r_busy      <= w_busy_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_bus_we    <= w_bus_we_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_be    <= w_bus_be_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      // Counter is held at 0 outside the response states so it starts at 0 on entry
      if ((r_state == S_R1) || (r_state == S_R2)) begin
        if (!bus_rvld) r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && dbusif_req) begin
      r_addr <= dbusif_addr;
      r_size <= dbusif_size;
      r_we   <= dbusif_w_rb;
      r_m    <= w_m_in;
      r_wd64 <= w_wd64_in;
    end
    if ((r_state == S_R1) && bus_rvld) r_lo <= bus_rdata;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_fin_err   = 1'b0;
    case (r_state)
      S_IDLE: if (dbusif_req) begin
        if (w_bad_in) begin
          w_state_nxt = S_FIN;
          w_fin_err   = 1'b1;
        end else begin
          w_state_nxt = S_A1;
        end
      end
      S_A1: if (bus_gnt) w_state_nxt = S_R1;
      S_R1: begin
        if (bus_rvld) begin
          if (bus_err) begin
            w_state_nxt = S_FIN;
            w_fin_err   = 1'b1;
          end else if (w_split) begin
            w_state_nxt = S_A2;
          end else begin
            w_state_nxt = S_FIN;
          end
        end else if (w_tmo) begin
          w_state_nxt = S_FIN;
          w_fin_err   = 1'b1;
        end
      end
      S_A2: if (bus_gnt) w_state_nxt = S_R2;
      S_R2: begin
        if (bus_rvld) begin
          w_state_nxt = S_FIN;
          w_fin_err   = bus_err;
        end else if (w_tmo) begin
          w_state_nxt = S_FIN;
          w_fin_err   = 1'b1;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: values the outputs take in the next state
  always_comb begin
    w_done_nxt      = (w_state_nxt == S_FIN);
    w_err_nxt       = w_fin_err;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_rd_nxt        = 32'h0;
    w_bus_req_nxt   = 1'b0;
    w_bus_we_nxt    = 1'b0;
    w_bus_addr_nxt  = 32'h0;
    w_bus_be_nxt    = 4'h0;
    w_bus_wdata_nxt = 32'h0;
    if (w_state_nxt == S_A1) begin
      w_bus_req_nxt   = 1'b1;
      w_bus_we_nxt    = w_src_we;
      w_bus_addr_nxt  = {w_src_addr[31:2], 2'b00};
      w_bus_be_nxt    = w_src_m[3:0];
      w_bus_wdata_nxt = w_src_wd64[31:0];
    end else if (w_state_nxt == S_A2) begin
      w_bus_req_nxt   = 1'b1;
      w_bus_we_nxt    = r_we;
      w_bus_addr_nxt  = {r_addr[31:2], 2'b00} + 32'd4;
      w_bus_be_nxt    = r_m[7:4];
      w_bus_wdata_nxt = r_wd64[63:32];
    end
    if ((w_state_nxt == S_FIN) && !w_fin_err && !r_we &&
        ((r_state == S_R1) || (r_state == S_R2)))
      w_rd_nxt = extract_rd(w_hilo, r_addr[1:0], r_size);
  end

  assign dbusif_done = r_done;
  assign dbusif_err  = r_err;
  assign dbusif_rd   = r_rd;
  assign busy        = r_busy;
  assign bus_req     = r_bus_req;
  assign bus_we      = r_bus_we;
  assign bus_addr    = r_bus_addr;
  assign bus_be      = r_bus_be;
  assign bus_wdata   = r_bus_wdata;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed testbench for dbus_ctrl (TIMEOUT=4, misalignment splitting enabled).
// Inputs are driven 1ns after a rising edge; outputs are sampled at that same
// point, which is well away from the active clock edge.
module tb_dbus_ctrl;
  logic        clk = 1'b0;
  logic        rst, dbusif_req, dbusif_w_rb;
  logic [1:0]  dbusif_size;
  logic [31:0] dbusif_addr, dbusif_wd;
  logic        dbusif_done, dbusif_err;
  logic [31:0] dbusif_rd;
  logic        busy, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvld, bus_err;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // {req, we, addr, be, wdata}
  wire [69:0] bus_vec  = {bus_req, bus_we, bus_addr, bus_be, bus_wdata};
  // {req, be, wdata} -- what must be quiet when no address phase is active
  wire [36:0] bus_idle = {bus_req, bus_be, bus_wdata};
  // {busy, done, err, rd}
  wire [34:0] rsp_vec  = {busy, dbusif_done, dbusif_err, dbusif_rd};

  always #5 clk = ~clk;

  dbus_ctrl #(.ALLOW_MISALIGN(1), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .dbusif_req(dbusif_req), .dbusif_w_rb(dbusif_w_rb), .dbusif_size(dbusif_size),
    .dbusif_addr(dbusif_addr), .dbusif_wd(dbusif_wd),
    .dbusif_done(dbusif_done), .dbusif_err(dbusif_err), .dbusif_rd(dbusif_rd), .busy(busy),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvld(bus_rvld), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request pulse at the current cycle; returns one cycle later.
  task automatic issue(input logic w_rb, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wd);
    dbusif_req = 1'b1; dbusif_w_rb = w_rb; dbusif_size = size;
    dbusif_addr = addr; dbusif_wd = wd;
    tick();
    dbusif_req = 1'b0; dbusif_w_rb = 1'b0; dbusif_size = 2'd0;
    dbusif_addr = 32'h0; dbusif_wd = 32'h0;
  endtask

  // One cycle of grant
  task automatic grant();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
  endtask

  // One cycle of response
  task automatic respond(input logic [31:0] data, input logic err);
    bus_rvld = 1'b1; bus_rdata = data; bus_err = err;
    tick();
    bus_rvld = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; dbusif_req = 1'b0; dbusif_w_rb = 1'b0; dbusif_size = 2'd0;
    dbusif_addr = 32'h0; dbusif_wd = 32'h0;
    bus_gnt = 1'b0; bus_rvld = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if (bus_vec !== 70'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h want %h", bus_vec, 70'h0);
    end
    n_tests++;
    if (rsp_vec !== 35'h0) begin
      n_fail++; $display("FAIL reset_rsp: got %h want %h", rsp_vec, 35'h0);
    end
    tick();
  endtask

  task automatic test_aligned_load();
    issue(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    n_tests++;
    if (bus_vec !== {1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0}) begin
      n_fail++; $display("FAIL aligned_beat: got %h want %h", bus_vec,
                         {1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0});
    end
    n_tests++;
    if (rsp_vec !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL aligned_busy: got %h want %h", rsp_vec, {1'b1, 1'b0, 1'b0, 32'h0});
    end
    grant();
    n_tests++;
    if (bus_idle !== 37'h0) begin
      n_fail++; $display("FAIL aligned_req_drop: got %h want %h", bus_idle, 37'h0);
    end
    respond(32'hDEAD_BEEF, 1'b0);
    n_tests++;
    if (rsp_vec !== {1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL aligned_done: got %h want %h", rsp_vec,
                         {1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF});
    end
    tick();
    n_tests++;
    if (rsp_vec !== 35'h0) begin
      n_fail++; $display("FAIL aligned_after: got %h want %h", rsp_vec, 35'h0);
    end
  endtask

  task automatic test_misaligned_store();
    issue(1'b1, 2'd2, 32'h0000_0103, 32'h1122_3344);
    n_tests++;
    if (bus_vec !== {1'b1, 1'b1, 32'h0000_0100, 4'h8, 32'h4400_0000}) begin
      n_fail++; $display("FAIL store_beat1: got %h want %h", bus_vec,
                         {1'b1, 1'b1, 32'h0000_0100, 4'h8, 32'h4400_0000});
    end
    tick();  // no grant yet: address phase must hold
    n_tests++;
    if (bus_vec !== {1'b1, 1'b1, 32'h0000_0100, 4'h8, 32'h4400_0000}) begin
      n_fail++; $display("FAIL store_hold: got %h want %h", bus_vec,
                         {1'b1, 1'b1, 32'h0000_0100, 4'h8, 32'h4400_0000});
    end
    grant();
    n_tests++;
    if (bus_idle !== 37'h0) begin
      n_fail++; $display("FAIL store_gap: got %h want %h", bus_idle, 37'h0);
    end
    respond(32'h0, 1'b0);
    n_tests++;
    if (bus_vec !== {1'b1, 1'b1, 32'h0000_0104, 4'h7, 32'h0011_2233}) begin
      n_fail++; $display("FAIL store_beat2: got %h want %h", bus_vec,
                         {1'b1, 1'b1, 32'h0000_0104, 4'h7, 32'h0011_2233});
    end
    grant();
    respond(32'h0, 1'b0);
    n_tests++;
    if (rsp_vec !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL store_done: got %h want %h", rsp_vec, {1'b1, 1'b1, 1'b0, 32'h0});
    end
    tick();
  endtask

  task automatic test_wrap_half_load();
    issue(1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0);
    n_tests++;
    if (bus_vec !== {1'b1, 1'b0, 32'hFFFF_FFFC, 4'h8, 32'h0}) begin
      n_fail++; $display("FAIL wrap_beat1: got %h want %h", bus_vec,
                         {1'b1, 1'b0, 32'hFFFF_FFFC, 4'h8, 32'h0});
    end
    grant();
    respond(32'hAB00_0000, 1'b0);
    n_tests++;
    if (bus_vec !== {1'b1, 1'b0, 32'h0000_0000, 4'h1, 32'h0}) begin
      n_fail++; $display("FAIL wrap_beat2: got %h want %h", bus_vec,
                         {1'b1, 1'b0, 32'h0000_0000, 4'h1, 32'h0});
    end
    grant();
    respond(32'h0000_00CD, 1'b0);
    n_tests++;
    if (rsp_vec !== {1'b1, 1'b1, 1'b0, 32'h0000_CDAB}) begin
      n_fail++; $display("FAIL wrap_rd: got %h want %h", rsp_vec, {1'b1, 1'b1, 1'b0, 32'h0000_CDAB});
    end
    tick();
  endtask

  task automatic test_beat1_err();
    issue(1'b0, 2'd2, 32'h0000_0202, 32'h0);
    n_tests++;
    if (bus_vec !== {1'b1, 1'b0, 32'h0000_0200, 4'hC, 32'h0}) begin
      n_fail++; $display("FAIL berr_beat1: got %h want %h", bus_vec,
                         {1'b1, 1'b0, 32'h0000_0200, 4'hC, 32'h0});
    end
    grant();
    respond(32'h1234_5678, 1'b1);
    n_tests++;
    if (rsp_vec !== {1'b1, 1'b1, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL berr_done: got %h want %h", rsp_vec, {1'b1, 1'b1, 1'b1, 32'h0});
    end
    n_tests++;
    if (bus_idle !== 37'h0) begin
      n_fail++; $display("FAIL berr_no_beat2: got %h want %h", bus_idle, 37'h0);
    end
    tick();
    n_tests++;
    if ({bus_idle, rsp_vec} !== 72'h0) begin
      n_fail++; $display("FAIL berr_after: got %h want %h", {bus_idle, rsp_vec}, 72'h0);
    end
  endtask

  task automatic test_timeout();
    issue(1'b0, 2'd2, 32'h0000_0010, 32'h0);
    grant();  // now in first cycle of the response phase
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (dbusif_done !== 1'b0) begin
        n_fail++; $display("FAIL tmo_early_done[%0d]: got %b want 0", i, dbusif_done);
      end
      tick();
    end
    n_tests++;
    if (rsp_vec !== {1'b1, 1'b1, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL tmo_done: got %h want %h", rsp_vec, {1'b1, 1'b1, 1'b1, 32'h0});
    end
    tick();
    respond(32'hFFFF_FFFF, 1'b0);  // stray response while idle
    n_tests++;
    if ({bus_idle, rsp_vec} !== 72'h0) begin
      n_fail++; $display("FAIL tmo_stray: got %h want %h", {bus_idle, rsp_vec}, 72'h0);
    end
  endtask

  task automatic test_illegal_size();
    issue(1'b0, 2'd3, 32'h0000_0040, 32'h0);
    n_tests++;
    if (rsp_vec !== {1'b1, 1'b1, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL ill_done: got %h want %h", rsp_vec, {1'b1, 1'b1, 1'b1, 32'h0});
    end
    n_tests++;
    if (bus_idle !== 37'h0) begin
      n_fail++; $display("FAIL ill_no_req: got %h want %h", bus_idle, 37'h0);
    end
    tick();
    n_tests++;
    if ({bus_idle, rsp_vec} !== 72'h0) begin
      n_fail++; $display("FAIL ill_after: got %h want %h", {bus_idle, rsp_vec}, 72'h0);
    end
  endtask

  task automatic test_reset_midflight();
    issue(1'b0, 2'd2, 32'h0000_0001, 32'h0);
    n_tests++;
    if (bus_vec !== {1'b1, 1'b0, 32'h0000_0000, 4'hE, 32'h0}) begin
      n_fail++; $display("FAIL rstmf_beat1: got %h want %h", bus_vec,
                         {1'b1, 1'b0, 32'h0000_0000, 4'hE, 32'h0});
    end
    grant();
    respond(32'h5555_5555, 1'b0);
    n_tests++;
    if (bus_vec !== {1'b1, 1'b0, 32'h0000_0004, 4'h1, 32'h0}) begin
      n_fail++; $display("FAIL rstmf_beat2: got %h want %h", bus_vec,
                         {1'b1, 1'b0, 32'h0000_0004, 4'h1, 32'h0});
    end
    grant();  // now waiting for the second response
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({bus_vec, rsp_vec} !== 105'h0) begin
      n_fail++; $display("FAIL rstmf_outputs: got %h want %h", {bus_vec, rsp_vec}, 105'h0);
    end
    tick();
    n_tests++;
    if (rsp_vec !== 35'h0) begin
      n_fail++; $display("FAIL rstmf_no_done: got %h want %h", rsp_vec, 35'h0);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 2'd0, 32'h0000_0001, 32'h0);
    n_tests++;
    if (bus_vec !== {1'b1, 1'b0, 32'h0000_0000, 4'h2, 32'h0}) begin
      n_fail++; $display("FAIL b2b_byte_beat: got %h want %h", bus_vec,
                         {1'b1, 1'b0, 32'h0000_0000, 4'h2, 32'h0});
    end
    grant();
    respond(32'h0000_AA00, 1'b0);
    n_tests++;
    if (rsp_vec !== {1'b1, 1'b1, 1'b0, 32'h0000_00AA}) begin
      n_fail++; $display("FAIL b2b_byte_rd: got %h want %h", rsp_vec,
                         {1'b1, 1'b1, 1'b0, 32'h0000_00AA});
    end
    tick();  // first cycle after done: new request allowed here
    n_tests++;
    if (rsp_vec !== 35'h0) begin
      n_fail++; $display("FAIL b2b_idle: got %h want %h", rsp_vec, 35'h0);
    end
    issue(1'b1, 2'd1, 32'h0000_0002, 32'h0000_BEEF);
    n_tests++;
    if (bus_vec !== {1'b1, 1'b1, 32'h0000_0000, 4'hC, 32'hBEEF_0000}) begin
      n_fail++; $display("FAIL b2b_half_beat: got %h want %h", bus_vec,
                         {1'b1, 1'b1, 32'h0000_0000, 4'hC, 32'hBEEF_0000});
    end
    grant();
    respond(32'h0, 1'b0);
    n_tests++;
    if (rsp_vec !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL b2b_half_done: got %h want %h", rsp_vec, {1'b1, 1'b1, 1'b0, 32'h0});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_aligned_load();
    test_misaligned_store();
    test_wrap_half_load();
    test_beat1_err();
    test_timeout();
    test_illegal_size();
    test_reset_midflight();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
